// File: rtl/bp_fe_pkg.sv
// Fetch-buffer entry layout and small helpers shared by the FE fetch buffer slice.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_mp, instr_width_mp, fetch_width_mp) \
   typedef struct packed {                                                      \
      logic [(vaddr_width_mp)-1:0]                    pc;                       \
      logic [((fetch_width_mp)*(instr_width_mp))-1:0] data;                     \
      logic                                           fault;                    \
   } bp_fe_fetch_entry_s

`define BP_FE_FETCH_ENTRY_WIDTH(vaddr_width_mp, instr_width_mp, fetch_width_mp) \
   ((vaddr_width_mp) + ((fetch_width_mp)*(instr_width_mp)) + 1)

package bp_fe_pkg;

   // Pointer increment that wraps at els-1, so depth need not be a power of two.
   function automatic int unsigned bp_fe_wrap_inc(input int unsigned ptr, input int unsigned els);
      return (ptr == els - 1) ? 0 : ptr + 1;
   endfunction

endpackage

`endif

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-file storage with asynchronous read.
module bsg_mem_1r1w
   import bp_fe_pkg::*;
#(
   parameter int width_p       = 8,
   parameter int els_p         = 4,
   parameter int addr_width_lp = $clog2(els_p)
)
(
   input  logic                     w_clk_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o
);

   logic [width_p-1:0] mem_q [els_p];

   always_ff @(posedge w_clk_i) begin
      if (w_v_i) mem_q[w_addr_i] <= w_data_i;
   end

   assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// Credit-based fetch-response buffer; stale in-flight responses after a redirect
// are discarded by counting them rather than by tagging.
module bp_fe_fetch_buffer
   import bp_fe_pkg::*;
#(
   parameter int els_p         = 4,
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32,
   parameter int fetch_width_p = 1
)
(
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   flush_i,
   input  logic                                   req_v_i,
   output logic                                   req_ready_o,
   input  logic                                   resp_v_i,
   input  logic [vaddr_width_p-1:0]               resp_pc_i,
   input  logic [fetch_width_p*instr_width_p-1:0] resp_data_i,
   input  logic                                   resp_fault_i,
   output logic                                   data_v_o,
   output logic [vaddr_width_p-1:0]               data_pc_o,
   output logic [fetch_width_p*instr_width_p-1:0] data_o,
   output logic                                   data_fault_o,
   input  logic                                   data_yumi_i,
   output logic [$clog2(els_p+1)-1:0]             credits_o
);

   localparam int ptr_w_lp   = $clog2(els_p);
   localparam int cnt_w_lp   = $clog2(els_p+1);
   localparam int entry_w_lp = `BP_FE_FETCH_ENTRY_WIDTH(vaddr_width_p, instr_width_p, fetch_width_p);

   `DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_p, instr_width_p, fetch_width_p);

   typedef logic [ptr_w_lp-1:0] ptr_t;
   typedef logic [cnt_w_lp-1:0] cnt_t;

   cnt_t o_q, o_d, d_q, d_d, f_q, f_d, used;
   ptr_t rptr_q, rptr_d, wptr_q, wptr_d;
   logic req_fire, resp_v, drop, enq, deq;
   bp_fe_fetch_entry_s wr_entry, rd_entry;

   assign used        = o_q + f_q;
   assign req_ready_o = (used < cnt_t'(els_p));
   assign credits_o   = used;

   // A response with nothing outstanding is a protocol error; keep O from wrapping.
   assign req_fire = req_v_i & req_ready_o;
   assign resp_v   = resp_v_i & (o_q != '0);
   assign drop     = resp_v & (d_q != '0);
   assign enq      = resp_v & ~drop & ~flush_i;
   assign deq      = data_yumi_i & (f_q != '0) & ~flush_i;

   always_comb begin
      o_d    = o_q + cnt_t'(req_fire) - cnt_t'(resp_v);
      d_d    = d_q - cnt_t'(drop);
      f_d    = f_q + cnt_t'(enq) - cnt_t'(deq);
      wptr_d = enq ? ptr_t'(bp_fe_wrap_inc(32'(wptr_q), els_p)) : wptr_q;
      rptr_d = deq ? ptr_t'(bp_fe_wrap_inc(32'(rptr_q), els_p)) : rptr_q;
      // Redirect: everything still in flight, including this cycle's request, is stale.
      if (flush_i) begin
         d_d    = o_d;
         f_d    = '0;
         rptr_d = wptr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         o_q    <= '0;
         d_q    <= '0;
         f_q    <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
      end else begin
         o_q    <= o_d;
         d_q    <= d_d;
         f_q    <= f_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
      end
   end

   assign wr_entry.pc    = resp_pc_i;
   assign wr_entry.data  = resp_data_i;
   assign wr_entry.fault = resp_fault_i;

   bsg_mem_1r1w #(
      .width_p (entry_w_lp),
      .els_p   (els_p)
   ) mem (
      .w_clk_i  (clk_i),
      .w_v_i    (enq & ~reset_i),
      .w_addr_i (wptr_q),
      .w_data_i (wr_entry),
      .r_addr_i (rptr_q),
      .r_data_o (rd_entry)
   );

   assign data_v_o     = (f_q != '0);
   assign data_pc_o    = rd_entry.pc;
   assign data_o       = rd_entry.data;
   assign data_fault_o = rd_entry.fault;

   a_resp_outstanding: assert property (@(posedge clk_i) disable iff (reset_i) resp_v_i |-> (o_q != '0));
   a_yumi_valid:       assert property (@(posedge clk_i) disable iff (reset_i) data_yumi_i |-> data_v_o);
   a_req_ready:        assert property (@(posedge clk_i) disable iff (reset_i) req_v_i |-> req_ready_o);

endmodule
